// File: rtl/pipe_pkg.sv
// Shared constants for pipeline-stage registers: control-word bit positions,
// the default bubble kill mask and the slot-count limit.
package pipe_pkg;

    localparam int unsigned MAX_DEPTH = 4;
    localparam int unsigned CTRL_W_DEFAULT = 16;

    // Control-word bit positions, ALUSrc2 down to RegWrite
    localparam int unsigned CTRL_ALU_SRC2  = 10;
    localparam int unsigned CTRL_ALU_SRC1  = 9;
    localparam int unsigned CTRL_JUMP      = 8;
    localparam int unsigned CTRL_ALU_OP2   = 7;
    localparam int unsigned CTRL_ALU_OP1   = 6;
    localparam int unsigned CTRL_BRANCH    = 5;
    localparam int unsigned CTRL_MEM_WRITE = 4;
    localparam int unsigned CTRL_MEM_EN    = 3;
    localparam int unsigned CTRL_ALU_OP0   = 2;
    localparam int unsigned CTRL_MEM_TO_REG = 1;
    localparam int unsigned CTRL_REG_WRITE = 0;

    // Side-effecting bits that must never survive into a bubble (16'h0139)
    localparam logic [CTRL_W_DEFAULT-1:0] DEFAULT_KILL_MASK =
        CTRL_W_DEFAULT'((1 << CTRL_JUMP) | (1 << CTRL_BRANCH) | (1 << CTRL_MEM_WRITE) |
                        (1 << CTRL_MEM_EN) | (1 << CTRL_REG_WRITE));

endpackage

// File: rtl/pipe_slot.sv
// One pipeline slot: valid/ctrl/data/err register with load (advance), hold and kill.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int unsigned       CTRL_W    = CTRL_W_DEFAULT,
    parameter int unsigned       DATA_W    = 64,
    parameter logic [CTRL_W-1:0] KILL_MASK = CTRL_W'(DEFAULT_KILL_MASK)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              kill,
    input  logic              dValid,
    input  logic [CTRL_W-1:0] dCtrl,
    input  logic [DATA_W-1:0] dData,
    input  logic              dErr,
    output logic              qValid,
    output logic [CTRL_W-1:0] qCtrl,
    output logic [DATA_W-1:0] qData,
    output logic              qErr
);

    logic              liveCapture;
    logic [CTRL_W-1:0] loadCtrl;

    // A bubble (invalid or killed) never carries side-effecting control bits
    assign liveCapture = dValid & ~kill;
    assign loadCtrl    = liveCapture ? dCtrl : (dCtrl & ~KILL_MASK);

    always_ff @(posedge clk) begin
        if (rst) begin
            qValid <= 1'b0;
            qCtrl  <= '0;
            qData  <= '0;
            qErr   <= 1'b0;
        end else if (load) begin
            qValid <= liveCapture;
            qCtrl  <= loadCtrl;
            qData  <= dData;
            qErr   <= dErr & ~kill;
        end else if (kill) begin
            qValid <= 1'b0;
            qCtrl  <= qCtrl & ~KILL_MASK;
            qErr   <= 1'b0;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline boundary register: DEPTH-slot shift chain with stall/flush,
// a stall-immune halt/reset side channel and a saturating bubble counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned       CTRL_W    = CTRL_W_DEFAULT,
    parameter int unsigned       DATA_W    = 64,
    parameter int unsigned       DEPTH     = 1,   // 1 .. MAX_DEPTH
    parameter logic [CTRL_W-1:0] KILL_MASK = CTRL_W'(DEFAULT_KILL_MASK)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              clr_cnt,
    input  logic              in_valid,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_err,
    input  logic              in_halt_n,
    output logic              out_valid,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err,
    output logic              out_halt_n,
    output logic              out_rst,
    output logic [15:0]       bubble_cnt
);

    logic              slotValid [DEPTH];
    logic [CTRL_W-1:0] slotCtrl  [DEPTH];
    logic [DATA_W-1:0] slotData  [DEPTH];
    logic              slotErr   [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : gSlot
        logic              dValid;
        logic [CTRL_W-1:0] dCtrl;
        logic [DATA_W-1:0] dData;
        logic              dErr;

        if (k == 0) begin : gHead
            assign dValid = in_valid;
            assign dCtrl  = in_ctrl;
            assign dData  = in_data;
            assign dErr   = in_err;
        end else begin : gChain
            assign dValid = slotValid[k-1];
            assign dCtrl  = slotCtrl[k-1];
            assign dData  = slotData[k-1];
            assign dErr   = slotErr[k-1];
        end

        pipe_slot #(
            .CTRL_W    (CTRL_W),
            .DATA_W    (DATA_W),
            .KILL_MASK (KILL_MASK)
        ) uSlot (
            .clk    (clk),
            .rst    (rst),
            .load   (~stall),
            .kill   (flush),
            .dValid (dValid),
            .dCtrl  (dCtrl),
            .dData  (dData),
            .dErr   (dErr),
            .qValid (slotValid[k]),
            .qCtrl  (slotCtrl[k]),
            .qData  (slotData[k]),
            .qErr   (slotErr[k])
        );
    end

    // Side channel shifts every cycle regardless of stall/flush; top bit is the output
    logic [DEPTH-1:0] sideHaltN;
    logic [DEPTH-1:0] sideRst;
    logic [DEPTH:0]   haltChain;
    logic [DEPTH:0]   rstChain;

    assign haltChain = {sideHaltN, in_halt_n};
    assign rstChain  = {sideRst, rst};

    always_ff @(posedge clk) begin
        if (rst) begin
            sideHaltN <= '1;
            sideRst   <= '1;
        end else begin
            sideHaltN <= haltChain[DEPTH-1:0];
            sideRst   <= rstChain[DEPTH-1:0];
        end
    end

    logic [15:0] bubbleCnt;
    logic        bubbleIn;

    assign bubbleIn = ~stall & (~in_valid | flush);

    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            bubbleCnt <= '0;
        end else if (bubbleIn && (bubbleCnt != 16'hFFFF)) begin
            bubbleCnt <= bubbleCnt + 16'd1;
        end
    end

    assign out_valid  = slotValid[DEPTH-1];
    assign out_ctrl   = slotCtrl[DEPTH-1];
    assign out_data   = slotData[DEPTH-1];
    assign out_halt_n = haltChain[DEPTH];
    assign out_rst    = rstChain[DEPTH];
    assign out_err    = slotValid[DEPTH-1] & slotErr[DEPTH-1] & ~out_rst;
    assign bubble_cnt = bubbleCnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: three instances (DEPTH 1, 2, 3) share one stimulus.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst, stall, flush, clrCnt;
    logic        inValid, inErr, inHaltN;
    logic [15:0] inCtrl;
    logic [63:0] inData;

    logic        o1Valid, o1Err, o1HaltN, o1Rst;
    logic [15:0] o1Ctrl, o1Bubble;
    logic [63:0] o1Data;
    logic        o2Valid, o2Err, o2HaltN, o2Rst;
    logic [15:0] o2Ctrl, o2Bubble;
    logic [63:0] o2Data;
    logic        o3Valid, o3Err, o3HaltN, o3Rst;
    logic [15:0] o3Ctrl, o3Bubble;
    logic [63:0] o3Data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DEPTH(1)) u1 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .clr_cnt(clrCnt),
        .in_valid(inValid), .in_ctrl(inCtrl), .in_data(inData), .in_err(inErr), .in_halt_n(inHaltN),
        .out_valid(o1Valid), .out_ctrl(o1Ctrl), .out_data(o1Data), .out_err(o1Err),
        .out_halt_n(o1HaltN), .out_rst(o1Rst), .bubble_cnt(o1Bubble));

    pipe_stage_reg #(.DEPTH(2)) u2 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .clr_cnt(clrCnt),
        .in_valid(inValid), .in_ctrl(inCtrl), .in_data(inData), .in_err(inErr), .in_halt_n(inHaltN),
        .out_valid(o2Valid), .out_ctrl(o2Ctrl), .out_data(o2Data), .out_err(o2Err),
        .out_halt_n(o2HaltN), .out_rst(o2Rst), .bubble_cnt(o2Bubble));

    pipe_stage_reg #(.DEPTH(3)) u3 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .clr_cnt(clrCnt),
        .in_valid(inValid), .in_ctrl(inCtrl), .in_data(inData), .in_err(inErr), .in_halt_n(inHaltN),
        .out_valid(o3Valid), .out_ctrl(o3Ctrl), .out_data(o3Data), .out_err(o3Err),
        .out_halt_n(o3HaltN), .out_rst(o3Rst), .bubble_cnt(o3Bubble));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        checks++; if (o1Valid !== 1'b0) begin errors++; $display("FAIL reset_valid1 got %0h want 0", o1Valid); end
        checks++; if (o1Ctrl !== 16'h0) begin errors++; $display("FAIL reset_ctrl1 got %0h want 0", o1Ctrl); end
        checks++; if (o1Data !== 64'h0) begin errors++; $display("FAIL reset_data1 got %0h want 0", o1Data); end
        checks++; if (o1Err !== 1'b0) begin errors++; $display("FAIL reset_err1 got %0h want 0", o1Err); end
        checks++; if (o1HaltN !== 1'b1) begin errors++; $display("FAIL reset_haltn1 got %0h want 1", o1HaltN); end
        checks++; if (o1Rst !== 1'b1) begin errors++; $display("FAIL reset_rst1 got %0h want 1", o1Rst); end
        checks++; if (o1Bubble !== 16'h0) begin errors++; $display("FAIL reset_bubble1 got %0h want 0", o1Bubble); end
        checks++; if (o3Valid !== 1'b0) begin errors++; $display("FAIL reset_valid3 got %0h want 0", o3Valid); end
        checks++; if (o3Rst !== 1'b1) begin errors++; $display("FAIL reset_rst3 got %0h want 1", o3Rst); end
        rst = 1'b0;
        repeat (4) step();
        checks++; if (o1Rst !== 1'b0) begin errors++; $display("FAIL reset_release1 got %0h want 0", o1Rst); end
        checks++; if (o3Rst !== 1'b0) begin errors++; $display("FAIL reset_release3 got %0h want 0", o3Rst); end
    endtask

    task automatic test_basic_shift();
        inValid = 1'b1; inCtrl = 16'hFFFF; inData = 64'h1234; inErr = 1'b0;
        step();
        checks++; if (o1Ctrl !== 16'hFFFF || o1Data !== 64'h1234) begin errors++; $display("FAIL shift_d1 got %0h/%0h want ffff/1234", o1Ctrl, o1Data); end
        checks++; if (o2Valid !== 1'b0) begin errors++; $display("FAIL shift_d2_early got %0h want 0", o2Valid); end
        inValid = 1'b0; inCtrl = 16'hFFFF; inData = 64'h0;
        step();
        checks++; if (o2Valid !== 1'b1) begin errors++; $display("FAIL shift_valid2 got %0h want 1", o2Valid); end
        checks++; if (o2Ctrl !== 16'hFFFF) begin errors++; $display("FAIL shift_ctrl2 got %0h want ffff", o2Ctrl); end
        checks++; if (o2Data !== 64'h1234) begin errors++; $display("FAIL shift_data2 got %0h want 1234", o2Data); end
        checks++; if (o2Err !== 1'b0) begin errors++; $display("FAIL shift_err2 got %0h want 0", o2Err); end
        checks++; if (o1Valid !== 1'b0 || o1Ctrl !== 16'hFEC6) begin errors++; $display("FAIL bubble_mask1 got %0h/%0h want 0/fec6", o1Valid, o1Ctrl); end
    endtask

    task automatic test_stall_hold();
        inValid = 1'b1; inCtrl = 16'hA5A5; inData = 64'h55AA; clrCnt = 1'b1;
        step();
        clrCnt = 1'b0;
        checks++; if (o1Ctrl !== 16'hA5A5 || o1Valid !== 1'b1) begin errors++; $display("FAIL stall_capture got %0h/%0h want a5a5/1", o1Ctrl, o1Valid); end
        stall = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            inValid = 1'b0; inCtrl = 16'(16'h1111 * i); inData = 64'(i);
            step();
            checks++; if (o1Ctrl !== 16'hA5A5 || o1Valid !== 1'b1 || o1Data !== 64'h55AA) begin errors++; $display("FAIL stall_hold%0d got %0h/%0h/%0h want a5a5/1/55aa", i, o1Ctrl, o1Valid, o1Data); end
            checks++; if (o1Bubble !== 16'h0) begin errors++; $display("FAIL stall_bubble%0d got %0h want 0", i, o1Bubble); end
        end
        stall = 1'b0;
    endtask

    task automatic test_flush_during_stall();
        inValid = 1'b1; inCtrl = 16'hFFFF; inData = 64'hDEAD; inErr = 1'b1;
        step();
        checks++; if (o1Err !== 1'b1) begin errors++; $display("FAIL fstall_err_pre got %0h want 1", o1Err); end
        stall = 1'b1; flush = 1'b1; inCtrl = 16'h0; inData = 64'hBEEF;
        step();
        checks++; if (o1Valid !== 1'b0) begin errors++; $display("FAIL fstall_valid got %0h want 0", o1Valid); end
        checks++; if (o1Ctrl !== 16'hFEC6) begin errors++; $display("FAIL fstall_ctrl got %0h want fec6", o1Ctrl); end
        checks++; if (o1Err !== 1'b0) begin errors++; $display("FAIL fstall_err got %0h want 0", o1Err); end
        checks++; if (o1Data !== 64'hDEAD) begin errors++; $display("FAIL fstall_data got %0h want dead", o1Data); end
        stall = 1'b0; flush = 1'b0; inErr = 1'b0;
    endtask

    task automatic test_flush_chain();
        for (int k = 1; k <= 3; k++) begin
            inValid = 1'b1; inCtrl = 16'hFFFF; inData = 64'(k);
            step();
        end
        checks++; if (o3Valid !== 1'b1 || o3Data !== 64'h1) begin errors++; $display("FAIL chain_fill got %0h/%0h want 1/1", o3Valid, o3Data); end
        flush = 1'b1; inData = 64'h4;
        step();
        checks++; if (o3Valid !== 1'b0 || o3Ctrl !== 16'hFEC6 || o3Data !== 64'h2) begin errors++; $display("FAIL chain_flush got %0h/%0h/%0h want 0/fec6/2", o3Valid, o3Ctrl, o3Data); end
        flush = 1'b0; inData = 64'h5;
        step();
        checks++; if (o3Valid !== 1'b0 || o3Ctrl !== 16'hFEC6 || o3Data !== 64'h3) begin errors++; $display("FAIL chain_squashed got %0h/%0h/%0h want 0/fec6/3", o3Valid, o3Ctrl, o3Data); end
        step();
        step();
        checks++; if (o3Valid !== 1'b1 || o3Ctrl !== 16'hFFFF || o3Data !== 64'h5) begin errors++; $display("FAIL chain_refill got %0h/%0h/%0h want 1/ffff/5", o3Valid, o3Ctrl, o3Data); end
        inValid = 1'b0;
    endtask

    task automatic test_reset_side_channel();
        inHaltN = 1'b0; rst = 1'b1; stall = 1'b1;
        step();
        step();
        checks++; if (o3Rst !== 1'b1 || o3HaltN !== 1'b1) begin errors++; $display("FAIL side_inrst got %0h/%0h want 1/1", o3Rst, o3HaltN); end
        checks++; if (o3Valid !== 1'b0) begin errors++; $display("FAIL rst_midstall got %0h want 0", o3Valid); end
        rst = 1'b0; stall = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            step();
            checks++; if (o3Rst !== (e < 3) || o3HaltN !== (e < 3)) begin errors++; $display("FAIL side_edge%0d got %0h/%0h want %0h/%0h", e, o3Rst, o3HaltN, (e < 3), (e < 3)); end
        end
        inHaltN = 1'b1;
    endtask

    task automatic test_bubble_counter();
        inValid = 1'b0; clrCnt = 1'b1;
        step();
        clrCnt = 1'b0;
        checks++; if (o1Bubble !== 16'h0) begin errors++; $display("FAIL bub_clear got %0h want 0", o1Bubble); end
        repeat (5) step();
        checks++; if (o1Bubble !== 16'd5 || o3Bubble !== 16'd5) begin errors++; $display("FAIL bub_five got %0h/%0h want 5/5", o1Bubble, o3Bubble); end
        repeat (65529) step();
        checks++; if (o1Bubble !== 16'hFFFE) begin errors++; $display("FAIL bub_fffe got %0h want fffe", o1Bubble); end
        repeat (3) step();
        checks++; if (o1Bubble !== 16'hFFFF) begin errors++; $display("FAIL bub_sat got %0h want ffff", o1Bubble); end
        clrCnt = 1'b1;
        step();
        clrCnt = 1'b0;
        checks++; if (o1Bubble !== 16'h0) begin errors++; $display("FAIL bub_clr_prio got %0h want 0", o1Bubble); end
        inValid = 1'b1; flush = 1'b1;
        step();
        checks++; if (o1Bubble !== 16'd1) begin errors++; $display("FAIL bub_flush got %0h want 1", o1Bubble); end
        inValid = 1'b0; flush = 1'b0; stall = 1'b1;
        step();
        checks++; if (o1Bubble !== 16'd1) begin errors++; $display("FAIL bub_stalled got %0h want 1", o1Bubble); end
        stall = 1'b0;
    endtask

    task automatic test_error_masking();
        inValid = 1'b1; inErr = 1'b1; inCtrl = 16'h0001; inData = 64'h7;
        rst = 1'b1; stall = 1'b1;
        step();
        checks++; if (o2Rst !== 1'b1 || o2Err !== 1'b0 || o2Valid !== 1'b0) begin errors++; $display("FAIL err_inrst got %0h/%0h/%0h want 1/0/0", o2Rst, o2Err, o2Valid); end
        rst = 1'b0; stall = 1'b0;
        step();
        checks++; if (o2Rst !== 1'b1 || o2Err !== 1'b0) begin errors++; $display("FAIL err_masked got %0h/%0h want 1/0", o2Rst, o2Err); end
        step();
        checks++; if (o2Rst !== 1'b0 || o2Valid !== 1'b1 || o2Err !== 1'b1) begin errors++; $display("FAIL err_live got %0h/%0h/%0h want 0/1/1", o2Rst, o2Valid, o2Err); end
        inValid = 1'b0;
        step();
        step();
        checks++; if (o2Valid !== 1'b0 || o2Err !== 1'b0) begin errors++; $display("FAIL err_invalid got %0h/%0h want 0/0", o2Valid, o2Err); end
        inErr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; clrCnt = 1'b0;
        inValid = 1'b0; inCtrl = 16'h0; inData = 64'h0; inErr = 1'b0; inHaltN = 1'b1;
        test_reset();
        test_basic_shift();
        test_stall_hold();
        test_flush_during_stall();
        test_flush_chain();
        test_reset_side_channel();
        test_bubble_counter();
        test_error_masking();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
